charattr_row_dbuf: RTL and testbench
====================================

Name: charattr_row_dbuf

Overview:
Parametrised, double-buffered character/attribute row memory for the text renderer, on a single clock. The host side builds the next row in the back bank while the video side reads the front bank, and a swap handshake exchanges the two banks. A hardware fill engine clears the back bank to a given attribute word, one column per cycle.

Parameters:
WIDTH, 32, bits per char/attr word
COLUMNS, 88, columns per row; legal range 1..2^COL_BITS
COL_BITS, 7, column index width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe to back bank
wr_col  in  COL_BITS  write column
wr_data  in  WIDTH  write word
wr_drop  out  1  one-cycle pulse: a write was discarded
fill_start  in  1  start back-bank fill
fill_value  in  WIDTH  fill word, sampled on the fill_start cycle
busy  out  1  fill in progress
swap_req  in  1  request a bank exchange
swap_ack  out  1  one-cycle pulse when the exchange takes effect
front  out  1  index of the bank currently being read
rd_en  in  1  read strobe on the front bank
rd_col  in  COL_BITS  read column
rd_data  out  WIDTH  read word
rd_valid  out  1  rd_data valid

Behaviour:
- Storage: 2*COLUMNS words. The back bank is !front. Memory contents are not reset.
- Reset (reset low, asynchronous): state=IDLE, front=0, busy=0, swap_ack=0, wr_drop=0, rd_valid=0, rd_data=0, swap pending flag cleared, fill counter=0.
- States:
  - IDLE -> FILL on fill_start. The fill value is latched and the counter is set to 0.
  - In FILL, each cycle writes the latched value to back[counter] and increments the counter.
  - After writing column COLUMNS-1, FILL -> IDLE.
  - busy=1 exactly for COLUMNS cycles, starting the cycle after fill_start.
- fill_start while in FILL: ignored.
- Writes:
  - In IDLE with wr_col<COLUMNS and no fill_start: the word is written to back[wr_col] at the clock edge.
  - wr_en in FILL, wr_en together with fill_start, or wr_col>=COLUMNS: the write is discarded and wr_drop pulses on the next cycle.
- Reads:
  - Latency 1. A rd_en at cycle n gives rd_valid=1 at n+1, with rd_data=front_bank[rd_col] using front as sampled at cycle n.
  - rd_col>=COLUMNS returns 0 with rd_valid=1.
  - Without rd_en, rd_valid=0 and rd_data holds its last value.
- Swap:
  - swap_req in IDLE with no fill_start: front toggles at that edge and swap_ack=1 on the next cycle.
  - swap_req during FILL, or together with fill_start: sets a pending flag. The toggle happens at the edge that writes the last fill column, and swap_ack pulses the cycle after.
  - Repeated swap_req while a swap is pending: merged into one swap.
- A write and a swap in the same cycle: the write lands in the pre-swap back bank, which becomes the new front.
- A read and a swap in the same cycle: the read returns old front data.
- Reset mid-fill: the fill aborts, the pending swap is lost, and partially filled contents stay in memory.

Optional Feature:
CHARATTR_ROW_OUTREG_EN
- Defined: an extra output register is added. Read latency becomes 2 cycles; rd_valid and rd_data are both delayed one cycle. The reset value of that stage is 0.
- Undefined: read latency is 1 cycle as above.

Test Plan:
- Reset, then fill_start with fill_value=32'h0000_0020 -> busy high exactly 88 cycles. Then swap_req -> swap_ack 1 cycle later and front=1. Read cols 0, 87 -> 32'h20 each, rd_valid one cycle after rd_en.
- In IDLE, write col 5=32'hDEADBEEF, then swap, then read col 5 -> 32'hDEADBEEF. The old front is now the back bank; writing it does not disturb reads.
- wr_en with wr_col=88, and wr_en during FILL -> wr_drop pulses each time and no memory word changes (verified by reading after swap).
- swap_req at fill cycle 10 -> no toggle until the last fill write; swap_ack exactly 1 cycle after busy falls; a second swap_req during the same fill gives only one toggle.
- Same-cycle write col 3=32'h1 + swap_req + rd_en col 3 -> rd_data is old front col 3; the next read of col 3 returns 32'h1.
- Assert reset at fill cycle 40 -> busy=0, front=0, swap_ack never pulses. With CHARATTR_ROW_OUTREG_EN defined, repeat the first scenario and check a read latency of 2.

Source files
------------

// File: rtl/charattr_row_dbuf.sv
// charattr_row_dbuf: double-buffered char/attr row memory with fill engine and swap handshake
// Define CHARATTR_ROW_OUTREG_EN to add an output register stage (read latency 2).
`timescale 1ns/1ps
module charattr_row_dbuf #(
   parameter int WIDTH    = 32,
   parameter int COLUMNS  = 88,
   parameter int COL_BITS = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [COL_BITS-1:0] wr_col,
   input  logic [WIDTH-1:0]    wr_data,
   output logic                wr_drop,
   input  logic                fill_start,
   input  logic [WIDTH-1:0]    fill_value,
   output logic                busy,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic                front,
   input  logic                rd_en,
   input  logic [COL_BITS-1:0] rd_col,
   output logic [WIDTH-1:0]    rd_data,
   output logic                rd_valid
);
   localparam logic IDLE = 1'b0;
   localparam logic FILL = 1'b1;
   localparam logic [COL_BITS:0]   NCOL = (COL_BITS+1)'(COLUMNS);
   localparam logic [COL_BITS-1:0] LAST = COL_BITS'(COLUMNS-1);
   logic [WIDTH-1:0] mem [0:2*COLUMNS-1];
   logic state, pend, idle_go, wr_ok, last, do_swap, we, rd_in, rv1;
   logic [COL_BITS-1:0] cnt;
   logic [COL_BITS:0] waddr, raddr;
   logic [WIDTH-1:0] fval, wdata, rd1;
   assign busy    = state == FILL;
   assign idle_go = state == IDLE && !fill_start;
   assign wr_ok   = wr_en && idle_go && ({1'b0, wr_col} < NCOL);
   assign last    = busy && cnt == LAST;
   // a pending swap (or one requested on the final fill cycle) lands with the last fill write
   assign do_swap = (swap_req && idle_go) || (last && (pend || swap_req));
   assign we      = wr_ok || busy;
   // bank base is the back bank for writes, the front bank for reads
   assign waddr   = (front ? '0 : NCOL) + {1'b0, busy ? cnt : wr_col};
   assign wdata   = busy ? fval : wr_data;
   assign raddr   = (front ? NCOL : '0) + {1'b0, rd_col};
   assign rd_in   = {1'b0, rd_col} < NCOL;
   // storage is deliberately not reset; fill and host writes never coincide
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // control state, swap handshake, drop flag and first read stage
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         front    <= 1'b0;
         pend     <= 1'b0;
         cnt      <= '0;
         fval     <= '0;
         swap_ack <= 1'b0;
         wr_drop  <= 1'b0;
         rv1      <= 1'b0;
         rd1      <= '0;
      end else begin
         swap_ack <= do_swap;
         wr_drop  <= wr_en && !wr_ok;
         front    <= front ^ do_swap;
         pend     <= last ? 1'b0 : pend || (swap_req && (busy || fill_start));
         if (state == IDLE && fill_start) begin
            state <= FILL;
            cnt   <= '0;
            fval  <= fill_value;
         end else if (busy) begin
            state <= last ? IDLE : FILL;
            cnt   <= last ? '0 : cnt + 1'b1;
         end
         rv1 <= rd_en;
         if (rd_en) rd1 <= rd_in ? mem[raddr] : '0;
      end
`ifdef CHARATTR_ROW_OUTREG_EN
   // optional output register: delays valid and data by one more cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rv1;
         rd_data  <= rd1;
      end
`else
   assign rd_valid = rv1;
   assign rd_data  = rd1;
`endif
endmodule

// File: tb/tb_charattr_row_dbuf.sv
// tb_charattr_row_dbuf: scoreboard bench for charattr_row_dbuf
`timescale 1ns/1ps
module tb_charattr_row_dbuf;
   localparam int W = 32;
   localparam int C = 88;
`ifdef CHARATTR_ROW_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   typedef struct { logic [W-1:0] d; int due; } rd_t;
   logic clk = 0, reset = 0;
   logic wr_en = 0, fill_start = 0, swap_req = 0, rd_en = 0;
   logic [6:0] wr_col = 0, rd_col = 0;
   logic [W-1:0] wr_data = 0, fill_value = 0;
   logic wr_drop, busy, swap_ack, front, rd_valid;
   logic [W-1:0] rd_data;
   logic [W-1:0] mdl [2][C];
   int mfront = 0, cyc = 0, tests = 0, fails = 0;
   rd_t sb[$];
   charattr_row_dbuf dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
      .wr_drop(wr_drop), .fill_start(fill_start), .fill_value(fill_value), .busy(busy),
      .swap_req(swap_req), .swap_ack(swap_ack), .front(front), .rd_en(rd_en),
      .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // scoreboard consumer: every valid read must match the oldest expected entry and its due cycle
   always @(negedge clk)
      if (reset && rd_valid) begin
         if (sb.size() == 0) check("rd_unexpected", 1, 0);
         else begin
            rd_t e;
            e = sb.pop_front();
            check("rd_data", rd_data, e.d);
            check("rd_latency", cyc, e.due);
         end
      end
   task automatic nxt;
      @(posedge clk);
      #2;
      wr_en = 0; fill_start = 0; swap_req = 0; rd_en = 0;
   endtask
   task automatic rd(input int col);
      rd_t e;
      e.d = (col < C) ? mdl[mfront][col] : '0;
      e.due = cyc + LAT;
      sb.push_back(e);
      rd_en = 1; rd_col = 7'(col);
      nxt;
   endtask
   task automatic wr(input int col, input logic [W-1:0] d);
      wr_en = 1; wr_col = 7'(col); wr_data = d;
      nxt;
   endtask
   task automatic fill_wait(input logic [W-1:0] v);
      int n;
      fill_start = 1; fill_value = v;
      nxt;
      n = 0;
      while (busy && n < 300) begin n++; nxt; end
      check("fill_busy_len", n, C);
      for (int i = 0; i < C; i++) mdl[1-mfront][i] = v;
   endtask
   task automatic swap;
      swap_req = 1;
      nxt;
      mfront = 1 - mfront;
      check("swap_ack", swap_ack, 1);
      check("swap_front", front, mfront);
      nxt;
      check("swap_ack_pulse", swap_ack, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n, acks;
      repeat (2) @(posedge clk);
      #2;
      check("rst_front", front, 0);
      check("rst_busy", busy, 0);
      check("rst_ack", swap_ack, 0);
      check("rst_drop", wr_drop, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_data", rd_data, 0);
      reset = 1;
      nxt;
      // fill back bank 1, swap it to the front, read its edges
      fill_wait(32'h20);
      swap;
      rd(0); rd(87); rd(88);
      // prepare bank 0, then host write and swap
      fill_wait(32'h55);
      wr(5, 32'hDEADBEEF);
      mdl[0][5] = 32'hDEADBEEF;
      check("wr_nodrop", wr_drop, 0);
      swap;
      rd(5);
      wr(5, 32'h1234);
      mdl[1][5] = 32'h1234;
      rd(5); rd(6);
      // fill with dropped writes and two merged swap requests
      fill_start = 1; fill_value = 32'h77; wr_en = 1; wr_col = 0; wr_data = 32'hBAD;
      nxt;
      check("drop_fillstart", wr_drop, 1);
      n = 0;
      while (busy && n < 300) begin
         if (n == 10 || n == 20) swap_req = 1;
         if (n == 15) begin wr_en = 1; wr_col = 2; wr_data = 32'hBAD; end
         if (n == 16) check("drop_in_fill", wr_drop, 1);
         if (n == 30) check("no_early_swap", front, 0);
         n++;
         nxt;
      end
      check("fill2_busy_len", n, C);
      for (int i = 0; i < C; i++) mdl[1][i] = 32'h77;
      mfront = 1;
      check("pend_ack", swap_ack, 1);
      check("pend_front", front, 1);
      nxt;
      check("pend_ack_once", swap_ack, 0);
      check("pend_one_toggle", front, 1);
      wr(88, 32'hBAD);
      check("drop_col88", wr_drop, 1);
      nxt;
      check("drop_pulse", wr_drop, 0);
      rd(0); rd(2); rd(87);
      // write + swap + read in the same cycle
      wr_en = 1; wr_col = 3; wr_data = 32'h1; swap_req = 1;
      rd(3);
      mdl[0][3] = 32'h1;
      mfront = 0;
      check("same_ack", swap_ack, 1);
      check("same_front", front, 0);
      rd(3); rd(5); rd(0);
      // reset in the middle of a fill with a pending swap
      fill_start = 1; fill_value = 32'h99;
      nxt;
      for (int i = 0; i < 40; i++) begin
         if (i == 5) swap_req = 1;
         nxt;
      end
      for (int i = 0; i < 40; i++) mdl[1][i] = 32'h99;
      reset = 0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_front", front, 0);
      check("midrst_valid", rd_valid, 0);
      @(posedge clk);
      #2;
      reset = 1;
      acks = 0;
      for (int i = 0; i < 100; i++) begin
         if (swap_ack) acks++;
         nxt;
      end
      check("midrst_no_ack", acks, 0);
      check("midrst_busy2", busy, 0);
      mfront = 0;
      swap;
      rd(0); rd(39); rd(40); rd(87);
      repeat (5) nxt;
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
